// File: rtl/cmip_app_cnt_sampler.sv
// cmip_app_cnt_sampler: captures and clears a cmip_app_cnt counter every WIN_CYC clocks,
// presenting a saturated snapshot, overflow flag and sequence number on a one-entry valid/ready slot.
module cmip_app_cnt_sampler #(
  parameter int unsigned width   = 16,
  parameter logic [31:0] WIN_CYC = 32'd100_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [width-1:0] cnt_i,
  input  logic             vld_i,
  output logic             cnt_clr_o,
  output logic [width-1:0] smp_data_o,
  output logic             smp_ovf_o,
  output logic [7:0]       smp_seq_o,
  output logic             smp_vld_o,
  input  logic             smp_rdy_i,
  output logic             smp_drop_o,
  output logic [15:0]      drop_cnt_o
);
  typedef enum logic {IDLE, RUN} state_e;
  localparam logic [31:0] LAST = WIN_CYC - 32'd1;
  localparam logic [31:0] PRE  = WIN_CYC - 32'd2;
  state_e           state_q, state_d;
  logic [31:0]      win_q, win_d;
  logic             clr_q, clr_d;
  logic             ovf_r_q, ovf_r_d;
  logic [7:0]       seq_q, seq_d;
  logic [width-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       sseq_q, sseq_d;
  logic             vld_q, vld_d;
  logic             drop_q, drop_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic [width:0]   sum;
  logic             cap, wrap, sum_ovf, take;
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    clr_d      = clr_q;
    ovf_r_d    = ovf_r_q;
    seq_d      = seq_q;
    data_d     = data_q;
    ovf_d      = ovf_q;
    sseq_d     = sseq_q;
    vld_d      = vld_q && !smp_rdy_i;
    drop_d     = 1'b0;
    drop_cnt_d = drop_cnt_q;
    cap        = 1'b0;
    // the end-cycle vld is masked by clr inside the counter, so it is added here
    sum        = {1'b0, cnt_i} + {{width{1'b0}}, vld_i};
    sum_ovf    = ovf_r_q | sum[width];
    wrap       = vld_i && (&cnt_i) && !clr_q;
    take       = !vld_q || smp_rdy_i;
    if (state_q == IDLE) begin
      if (en) begin
        state_d = RUN;
        clr_d   = 1'b0;
        win_d   = '0;
        ovf_r_d = 1'b0;
      end
    end else if (!en) begin
      state_d = IDLE;
      clr_d   = 1'b1;
      win_d   = '0;
    end else begin
      cap     = win_q == LAST;
      win_d   = cap ? '0 : win_q + 32'd1;
      clr_d   = win_q == PRE;
      ovf_r_d = !cap && (ovf_r_q || wrap);
    end
    if (cap) begin
      seq_d = seq_q + 8'd1;
      if (take) begin
        vld_d  = 1'b1;
        data_d = sum_ovf ? '1 : sum[width-1:0];
        ovf_d  = sum_ovf;
        sseq_d = seq_q;
      end else begin
        drop_d     = 1'b1;
        drop_cnt_d = drop_cnt_q + {15'd0, ~&drop_cnt_q};
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      win_q      <= '0;
      clr_q      <= 1'b1;
      ovf_r_q    <= 1'b0;
      seq_q      <= '0;
      data_q     <= '0;
      ovf_q      <= 1'b0;
      sseq_q     <= '0;
      vld_q      <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      clr_q      <= clr_d;
      ovf_r_q    <= ovf_r_d;
      seq_q      <= seq_d;
      data_q     <= data_d;
      ovf_q      <= ovf_d;
      sseq_q     <= sseq_d;
      vld_q      <= vld_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  assign cnt_clr_o  = clr_q;
  assign smp_data_o = data_q;
  assign smp_ovf_o  = ovf_q;
  assign smp_seq_o  = sseq_q;
  assign smp_vld_o  = vld_q;
  assign smp_drop_o = drop_q;
  assign drop_cnt_o = drop_cnt_q;
endmodule

// File: tb/tb_cmip_app_cnt_sampler.sv
// tb_cmip_app_cnt_sampler: two samplers (16- and 40-cycle windows) on modelled counters,
// compared every cycle against a window-level event-count model.
module tb_cmip_app_cnt_sampler;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, vld = 1'b0, rdy = 1'b1;
  logic [3:0]  cnt    [2];
  logic        clr_o  [2];
  logic [3:0]  data_o [2];
  logic        ovf_o  [2];
  logic [7:0]  seq_o  [2];
  logic        vld_o  [2];
  logic        drop_o [2];
  logic [15:0] dcnt_o [2];
  int checks = 0, errors = 0;
  int win [2] = '{16, 40};
  bit run [2], sv [2], so [2], dr [2], clr [2];
  int ph [2], ev [2];
  logic [7:0] sq [2], ss [2];
  logic [3:0] sd [2];
  logic [15:0] dc [2];
  always #5 clk = ~clk;
  cmip_app_cnt_sampler #(.width(4), .WIN_CYC(32'd16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .cnt_i(cnt[0]), .vld_i(vld), .cnt_clr_o(clr_o[0]),
    .smp_data_o(data_o[0]), .smp_ovf_o(ovf_o[0]), .smp_seq_o(seq_o[0]), .smp_vld_o(vld_o[0]),
    .smp_rdy_i(rdy), .smp_drop_o(drop_o[0]), .drop_cnt_o(dcnt_o[0]));
  cmip_app_cnt_sampler #(.width(4), .WIN_CYC(32'd40)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .cnt_i(cnt[1]), .vld_i(vld), .cnt_clr_o(clr_o[1]),
    .smp_data_o(data_o[1]), .smp_ovf_o(ovf_o[1]), .smp_seq_o(seq_o[1]), .smp_vld_o(vld_o[1]),
    .smp_rdy_i(rdy), .smp_drop_o(drop_o[1]), .drop_cnt_o(dcnt_o[1]));
  // the upstream cmip_app_cnt: clr has priority over vld, wraps silently
  always @(posedge clk or negedge rst_n)
    for (int i = 0; i < 2; i++)
      if (!rst_n) cnt[i] <= 4'd0;
      else cnt[i] <= clr_o[i] ? 4'd0 : cnt[i] + {3'd0, vld};
  task automatic chk(input string tag, input int i, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s[%0d] got %0h exp %0h", tag, i, o, e);
    end
  endtask
  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      run[i] = 0; sv[i] = 0; so[i] = 0; dr[i] = 0; clr[i] = 1;
      ph[i] = 0; ev[i] = 0; sq[i] = 0; ss[i] = 0; sd[i] = 0; dc[i] = 0;
    end
  endtask
  // one clock edge of the reference: count events per completed window, then offer to the slot
  task automatic mupd(input bit e, input bit v, input bit r);
    for (int i = 0; i < 2; i++) begin
      bit cap;
      cap = 0;
      if (!run[i]) begin
        if (e) begin run[i] = 1; ph[i] = 0; ev[i] = 0; end
      end else if (!e) run[i] = 0;
      else begin
        ev[i] += int'(v);
        ph[i]++;
        if (ph[i] == win[i]) begin cap = 1; ph[i] = 0; end
      end
      dr[i] = 0;
      if (cap) begin
        if (!sv[i] || r) begin
          sv[i] = 1;
          sd[i] = ev[i] > 15 ? 4'hF : ev[i][3:0];
          so[i] = ev[i] > 15;
          ss[i] = sq[i];
        end else begin
          dr[i] = 1;
          if (dc[i] != 16'hFFFF) dc[i]++;
        end
        sq[i]++;
        ev[i] = 0;
      end else if (sv[i] && r) sv[i] = 0;
      clr[i] = !run[i] || ph[i] == win[i] - 1;
    end
  endtask
  task automatic cmp();
    for (int i = 0; i < 2; i++) begin
      chk("clr", i, clr_o[i], clr[i]);
      chk("vld", i, vld_o[i], sv[i]);
      chk("data", i, data_o[i], sd[i]);
      chk("ovf", i, ovf_o[i], so[i]);
      chk("seq", i, seq_o[i], ss[i]);
      chk("drop", i, drop_o[i], dr[i]);
      chk("dcnt", i, dcnt_o[i], dc[i]);
    end
  endtask
  task automatic rst_chk();
    for (int i = 0; i < 2; i++) begin
      chk("rst_clr", i, clr_o[i], 1);
      chk("rst_vld", i, vld_o[i], 0);
      chk("rst_data", i, data_o[i], 0);
      chk("rst_ovf", i, ovf_o[i], 0);
      chk("rst_seq", i, seq_o[i], 0);
      chk("rst_drop", i, drop_o[i], 0);
      chk("rst_dcnt", i, dcnt_o[i], 0);
    end
  endtask
  task automatic step(input bit e, input bit v, input bit r);
    @(negedge clk);
    cmp();
    en = e; vld = v; rdy = r;
    mupd(e, v, r);
  endtask
  initial begin
    mreset();
    repeat (3) @(negedge clk);
    rst_chk();
    rst_n = 1'b1;
    mupd(0, 0, 1);
    repeat (20) step(0, 0, 1);
    step(1, 0, 1);
    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 16; j++) begin
        step(1, j < 9 || j == 15, 1);
        if (w == 0 && j == 15) chk("pre_vld", 0, vld_o[0], 0);
        if (w > 0 && j == 0) begin
          chk("win_vld", 0, vld_o[0], 1);
          chk("win_data", 0, data_o[0], 10);
          chk("win_seq", 0, seq_o[0], w - 1);
        end
      end
    step(1, 0, 1);
    chk("win_data", 0, data_o[0], 10);
    chk("win_seq", 0, seq_o[0], 2);
    step(0, 0, 1);
    step(1, 0, 1);
    repeat (16) step(1, 1, 1);
    step(1, 0, 1);
    chk("full_data", 0, data_o[0], 15);
    chk("full_ovf", 0, ovf_o[0], 1);
    step(0, 0, 1);
    step(1, 0, 1);
    for (int j = 0; j < 40; j++) step(1, (j % 2) == 1, 1);
    step(1, 0, 1);
    chk("wrap_vld", 1, vld_o[1], 1);
    chk("wrap_data", 1, data_o[1], 15);
    chk("wrap_ovf", 1, ovf_o[1], 1);
    step(0, 0, 1);
    step(1, 0, 0);
    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 16; j++) begin
        step(1, w == 0 ? j < 3 : w == 1 ? j < 5 : j < 7, w == 2 && j == 15);
        if (w == 2 && j == 0) begin
          chk("hold_data", 0, data_o[0], 3);
          chk("hold_drop", 0, drop_o[0], 1);
          chk("hold_dcnt", 0, dcnt_o[0], 1);
        end
      end
    step(1, 0, 1);
    chk("refill_vld", 0, vld_o[0], 1);
    chk("refill_data", 0, data_o[0], 7);
    chk("refill_drop", 0, drop_o[0], 0);
    step(0, 0, 1);
    step(1, 0, 1);
    repeat (5) step(1, 1, 1);
    step(0, 1, 1);
    step(0, 0, 1);
    chk("abort_clr", 0, clr_o[0], 1);
    chk("abort_vld", 0, vld_o[0], 0);
    step(1, 0, 1);
    for (int j = 0; j < 16; j++) step(1, j < 4, 1);
    step(1, 0, 1);
    chk("fresh_data", 0, data_o[0], 4);
    repeat (400) step($urandom_range(0, 39) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    en = 1'b0; vld = 1'b0;
    #1 rst_chk();
    mreset();
    @(negedge clk);
    rst_n = 1'b1;
    mupd(0, 0, rdy);
    repeat (400) step($urandom_range(0, 39) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
    step(0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
